warp_mem_arbiter: RTL
=====================

# warp_mem_arbiter

Shares the warp engine's single memory port (mem_req_*/mem_resp_*) between the instruction-fetch unit and the per-lane load/store units. Each cycle it grants at most one requester, forwards its request to memory, records the requester index of every read in an in-order tag FIFO, and routes returning read data back to the issuing requester. Sits between the fetch/LSU logic inside warp_engine and the external memory interface.

## Interface
- NUM_LANES, 8, number of lane requesters; total requesters N_REQ = NUM_LANES+1 (index 0 = fetch, 1..NUM_LANES = lanes)
- DATA_WIDTH, 32, data width
- ADDR_WIDTH, 32, address width
- MAX_OUTSTANDING, 4, tag FIFO depth (max reads in flight); power of two, >= 2

- clk  input  1  clock; one clock domain
- rst  input  1  reset; synchronous, active-high
- req_valid  input  N_REQ  per-requester request valid
- req_ready  output  N_REQ  per-requester request accepted
- req_addr  input  N_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_write  input  N_REQ  1 = write, 0 = read
- req_wdata  input  N_REQ*DATA_WIDTH  flattened write data
- resp_valid  output  N_REQ  one-hot read-response valid
- resp_ready  input  N_REQ  per-requester response ready
- resp_data  output  DATA_WIDTH  shared read data (= mem_resp_data)
- mem_req_valid  output  1  to memory
- mem_req_ready  input  1  from memory
- mem_req_addr  output  ADDR_WIDTH  granted address
- mem_req_write  output  1  granted write flag
- mem_req_data  output  DATA_WIDTH  granted write data
- mem_resp_valid  input  1  read data valid
- mem_resp_ready  output  1  read data accepted
- mem_resp_data  input  DATA_WIDTH  read data
- outstanding  output  $clog2(MAX_OUTSTANDING)+1  reads in flight
- stray_resp_err  output  1  sticky: response arrived with no read outstanding

## Operation
- Eligible requester: req_valid[i] && (req_write[i] || count < MAX_OUTSTANDING).
- Arbitration: round-robin pointer rr_ptr; first eligible index at or after rr_ptr (wrapping N_REQ-1 -> 0) wins. Fetch priority per Configuration.
- mem_req_valid = any eligible; mem_req_addr/write/data muxed from winner; all zero when no winner.
- req_ready[winner] = mem_req_valid && mem_req_ready; all other bits 0. At most one bit set.
- On accepted handshake: rr_ptr <= (winner+1) mod N_REQ; if read, push winner index into tag FIFO.
- Writes produce no response and are not tagged.
- Responses: when FIFO non-empty, head tag h: resp_valid[h] = mem_resp_valid, mem_resp_ready = resp_ready[h]; pop on mem_resp_valid && mem_resp_ready. Responses strictly in issue order.
- FIFO empty: resp_valid = 0, mem_resp_ready = 1 (drain); mem_resp_valid in this state sets stray_resp_err, data discarded. Cleared only by rst.
- Full: count == MAX_OUTSTANDING blocks reads only; writes still granted. Full check uses registered count; a same-cycle pop does not unblock a read (no bypass).
- Simultaneous push and pop when not full/empty: count unchanged, both pointers advance.

## Timing
- Request path combinational: req -> mem_req in same cycle; zero added latency.
- Response path combinational: mem_resp -> resp same cycle.
- State updates on posedge clk: rr_ptr, FIFO pointers, count, stray_resp_err.
- Reset (rst high at posedge): rr_ptr = 1, FIFO empty, count = 0, stray_resp_err = 0. During/after reset with no requests: mem_req_valid = 0, req_ready = 0, resp_valid = 0, mem_resp_ready = 1, outstanding = 0.
- Reset mid-operation discards all in-flight tags; responses returning afterwards are stray and set stray_resp_err.
- Pointers wrap modulo MAX_OUTSTANDING; count saturates by construction (never exceeds MAX_OUTSTANDING).

## Configuration
- WARP_MEM_ARB_FETCH_PRIO_EN defined: requester 0 (fetch) has fixed highest priority; when eligible it wins regardless of rr_ptr, and rr_ptr is not updated on its grant. Lanes round-robin among themselves (rr_ptr ranges 1..NUM_LANES).
- Undefined: fetch participates in plain round-robin over all N_REQ requesters.

## Test plan
- Single read: req_valid[0]=1, addr 0x0, mem_req_ready=1 -> mem_req_valid same cycle, req_ready[0]=1, outstanding=1; mem_resp 0x0A000000 next cycle -> resp_valid=9'b000000001, outstanding=0.
- Round-robin (macro undefined): lanes 1,2,3 hold reads continuously -> grant order 1,2,3,1,...; responses routed in same order.
- Fetch priority (macro defined): fetch and lanes 2,5 valid every cycle -> fetch wins each cycle, lanes starved only while fetch valid; after fetch drops, 2 then 5.
- Full: 4 reads issued, no responses -> 5th read req_ready=0, concurrent write from lane 3 accepted; one response pop -> read accepted next cycle, not same cycle.
- Backpressure: resp_ready[head]=0 with mem_resp_valid=1 -> mem_resp_ready=0, no pop; release -> pop, correct lane.
- Stray/reset: rst mid-flight with 2 reads outstanding, then mem_resp_valid=1 -> outstanding=0, stray_resp_err=1, all resp_valid=0.

Source files
------------

// File: rtl/warp_mem_arbiter.sv
// ---------------------------------------------------------------------------
// warp_mem_arbiter
//
// Shares the warp engine's single memory port between the instruction-fetch
// unit (requester 0) and the per-lane load/store units (requesters
// 1..NUM_LANES).
//
// Each cycle at most one requester is granted, and its request goes straight
// to memory. Every accepted read pushes its requester index into an in-order
// tag FIFO. Returning read data is steered to the requester named by the FIFO
// head.
//
// Build option:
//   WARP_MEM_ARB_FETCH_PRIO_EN
//     When defined, fetch has fixed top priority and does not move the
//     round-robin pointer. The lanes round-robin among themselves.
//     When undefined, all requesters share a single round-robin.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/ready       per-requester request handshake
//   req_addr/write/wdata  flattened per-requester request payload
//   resp_valid/ready      per-requester read-response handshake (valid is one-hot)
//   resp_data             shared read data
//   mem_req_*             request channel to memory
//   mem_resp_*            read-response channel from memory
//   outstanding           number of reads in flight
//   stray_resp_err        sticky flag: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module warp_mem_arbiter #(
  parameter  int NUM_LANES       = 8,
  parameter  int DATA_WIDTH      = 32,
  parameter  int ADDR_WIDTH      = 32,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int N_REQ           = NUM_LANES + 1,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            resp_valid,
  input  logic [N_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]       resp_data,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output logic                        mem_req_write,
  output logic [DATA_WIDTH-1:0]       mem_req_data,
  input  logic                        mem_resp_valid,
  output logic                        mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]       mem_resp_data,
  output logic [CNT_W-1:0]            outstanding,
  output logic                        stray_resp_err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int TAG_W = $clog2(N_REQ);

  // Round-robin pointer: index where the search for a winner starts.
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;

  // Tag FIFO holding the requester index of each read in flight, in issue order.
  logic [TAG_W-1:0] tag_mem_q [MAX_OUTSTANDING];
  logic [TAG_W-1:0] tag_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stray_q, stray_d;

  logic [N_REQ-1:0] eligible;
  logic             grant_found;
  logic [TAG_W-1:0] winner;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [TAG_W-1:0] head_tag;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign head_tag   = tag_mem_q[rd_ptr_q];

  // Reads are held back only by the registered count. A pop in the same
  // cycle does not free a slot early, which keeps the full check off the
  // response path.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (req_write[i] || !fifo_full);
    end
  end

  // Winner selection: take the first eligible index at or after rr_ptr,
  // wrapping around.
`ifdef WARP_MEM_ARB_FETCH_PRIO_EN
  // Fetch pre-empts the lanes. The lanes rotate over 1..NUM_LANES only.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    winner      = '0;
    if (eligible[0]) begin
      grant_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        idx = 1 + ((int'(rr_ptr_q) - 1 + k) % NUM_LANES);
        if (!grant_found && eligible[idx]) begin
          grant_found = 1'b1;
          winner      = TAG_W'(idx);
        end
      end
    end
  end
`else
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    winner      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        winner      = TAG_W'(idx);
      end
    end
  end
`endif

  assign accept = grant_found && mem_req_ready;
  assign push   = accept && !req_write[winner];

  // Request channel: the winner's payload is forwarded combinationally.
  // Everything is driven to zero when there is no winner.
  always_comb begin
    req_ready     = '0;
    mem_req_valid = grant_found;
    mem_req_addr  = '0;
    mem_req_write = 1'b0;
    mem_req_data  = '0;
    if (grant_found) begin
      mem_req_addr  = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_req_write = req_write[winner];
      mem_req_data  = req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Response channel: the FIFO head names the requester that owns the data.
  // With nothing outstanding, any response is accepted and dropped so the
  // memory side never stalls.
  always_comb begin
    resp_valid     = '0;
    mem_resp_ready = 1'b1;
    if (!fifo_empty) begin
      resp_valid[head_tag] = mem_resp_valid;
      mem_resp_ready       = resp_ready[head_tag];
    end
  end

  assign pop       = !fifo_empty && mem_resp_valid && resp_ready[head_tag];
  assign resp_data = mem_resp_data;

  // Pointer advance after an accepted grant. In fetch-priority builds, a
  // fetch grant leaves the lane rotation untouched.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
`ifdef WARP_MEM_ARB_FETCH_PRIO_EN
      if (winner != '0) begin
        rr_ptr_d = (int'(winner) == NUM_LANES) ? TAG_W'(1) : winner + 1'b1;
      end
`else
      rr_ptr_d = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
`endif
    end
  end

  // FIFO bookkeeping. Reads cannot be granted while full and pops need a
  // non-empty FIFO, so the count stays within 0..MAX_OUTSTANDING.
  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = winner;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // The stray flag is sticky until reset.
  always_comb begin
    stray_d = stray_q | (fifo_empty && mem_resp_valid);
  end

  // Reset empties the FIFO, discarding any tags that were in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= TAG_W'(1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stray_q  <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      stray_q   <= stray_d;
      tag_mem_q <= tag_mem_d;
    end
  end

  assign outstanding    = count_q;
  assign stray_resp_err = stray_q;

endmodule
